sdram_arbiter: RTL and testbench
================================

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 25: width of all address buses.
REQ-002 Parameter DATA_WIDTH, default 16: width of all data buses.
REQ-003 Parameter NUM_WIDTH, default 10: width of all access_num buses (burst length in words).
REQ-004 One clock, `sdram_clock`; reset is `reset`, synchronous, active-high.
REQ-005 Ports are listed as name, direction, width, meaning:
- sdram_clock, in, 1: clock.
- reset, in, 1: synchronous active-high reset.
REQ-006 Requester ports, per port n = 0 (CPU) and n = 1 (video/DMA):
- pn_address, in, ADDR_WIDTH: word address.
- pn_access_num, in, NUM_WIDTH: burst length.
- pn_data_in, in, DATA_WIDTH: write data.
- pn_write_req, in, 1: write request level.
- pn_read_req, in, 1: read request level.
- pn_data_out, out, DATA_WIDTH: last read word.
- pn_data_valid, out, 1: read word strobe.
- pn_write_strobe, out, 1: write word consumed.
- pn_done, out, 1: one-cycle completion pulse.
- pn_busy, out, 1: port currently granted.
REQ-007 Controller-side ports:
- access_address, out, ADDR_WIDTH.
- access_num, out, NUM_WIDTH.
- access_data_in, out, DATA_WIDTH.
- access_data_out, in, DATA_WIDTH.
- write_request, out, 1.
- read_request, out, 1.
- write_flag, in, 1.
- read_flag, in, 1.
- idle, in, 1.

Function
REQ-008 The FSM SHALL have the states IDLE, GRANT, XFER, DRAIN and DONE.
REQ-009 In IDLE, any request pending SHALL select a port, register the grant and the operation, and move to GRANT on the next edge.
REQ-010 A port whose pn_write_req and pn_read_req are both high SHALL be served as a write.
REQ-011 In GRANT, write_request or read_request SHALL be driven high for the granted port.
- The FSM SHALL move to XFER on the first cycle write_flag or read_flag is high.
REQ-012 In XFER, write_request and read_request SHALL be low.
- The FSM SHALL move to DRAIN when the flag drops.
REQ-013 In DRAIN, the FSM SHALL move to DONE when idle is high.
REQ-014 In DONE, pn_done SHALL be high for exactly one cycle, and the FSM SHALL return to IDLE.
REQ-015 The port just completed SHALL be ineligible for selection in the IDLE cycle immediately after DONE.
REQ-016 In GRANT, XFER and DRAIN, access_address, access_num and access_data_in SHALL be a combinational mux of the granted port's inputs.
- In IDLE and DONE, all three SHALL be 0.
REQ-017 pn_write_strobe SHALL equal write_flag while port n is granted, and 0 otherwise.
REQ-018 On each cycle read_flag is high for granted port n:
- pn_data_out SHALL register access_data_out.
- pn_data_valid SHALL pulse one cycle later, aligned with the new pn_data_out.
- pn_data_out SHALL hold between strobes.
REQ-019 A request deasserted mid-operation SHALL NOT abort the access; it SHALL complete through DONE and pn_done still pulses.
REQ-020 A request rising while another port is granted SHALL wait; it SHALL NOT be lost while held high.
REQ-021 pn_busy SHALL be high from GRANT through DONE for the granted port only.
- At most one pn_busy SHALL be high at any time.
REQ-022 Requester handshake: a requester holds its request and inputs stable until pn_done, then drops the request no later than the cycle after pn_done.

Reset
REQ-023 Reset SHALL force the FSM to IDLE.
- All outputs SHALL be 0, including pn_data_out, pn_busy, write_request and read_request.
- The round-robin pointer SHALL be set to port 0.
REQ-024 Reset asserted mid-burst SHALL take effect on the next edge with no completion pulse.
- The controller shares the same reset.

Configuration
REQ-025 With SDRAM_ARB_ROUND_ROBIN_EN defined, selection SHALL be round-robin.
- The pointer SHALL advance to the other port after each DONE.
- When both ports request, the port not last served SHALL win.
REQ-026 Without SDRAM_ARB_ROUND_ROBIN_EN, port 0 SHALL have fixed priority whenever both ports request in IDLE.

Structure
REQ-027 Package sdram_arb_pkg SHALL hold the state enum, the port-index type and the operation type (OP_READ, OP_WRITE).
REQ-028 The port-selection logic SHALL be one sub-module, sdram_arb_select (inputs: requests, pointer, lockout; outputs: valid and index).
- The macro SHALL be confined to this sub-module.
REQ-029 The implementation SHALL total 120-400 lines of RTL.

Verification
REQ-030 p0 write, addr 0x0001234, num 1, data 0x00A5; controller model raises write_flag 3 cycles later for 1 cycle -> write_request high in GRANT only, p0_write_strobe 1 cycle, p0_done 1 cycle after idle.
REQ-031 p1 read, num 4; model returns 0x1111..0x4444 -> four p1_data_valid pulses with matching p1_data_out; p1_data_out holds 0x4444 after p1_done.
REQ-032 p0 and p1 request in the same cycle, three times in a row -> grants 0,1,0 with macro defined; grants 0,0,0 without it (p1 starved while p0 re-requests).
REQ-033 p0 drops its request during XFER -> burst completes, p0_done pulses, and no new grant to p0 occurs in the following IDLE.
REQ-034 reset asserted during XFER of a 4-word read -> next cycle the FSM is in IDLE, all outputs are 0, and no pn_done pulse occurs.
REQ-035 p0 with both write and read high -> write_request asserted and read_request never asserted.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: types shared by the two-port SDRAM arbiter and its
// port-selection logic.
package sdram_arb_pkg;

  localparam int NUM_PORTS = 2;

  // Arbiter FSM states.
  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    XFER,
    DRAIN,
    DONE
  } state_t;

  // Index of a requester port: 0 = CPU, 1 = video/DMA.
  typedef logic port_idx_t;

  // Operation latched at grant time.
  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  // One-hot mask with only the given port's bit set.
  function automatic logic [NUM_PORTS-1:0] port_onehot(input port_idx_t idx);
    logic [NUM_PORTS-1:0] mask;
    mask      = '0;
    mask[idx] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/sdram_arb_select.sv
// sdram_arb_select: picks which requester is granted next.
// Build option: define SDRAM_ARB_ROUND_ROBIN_EN for round-robin selection;
// by default port 0 has fixed priority. A locked-out port (the one that
// just completed) is never eligible.
module sdram_arb_select
  import sdram_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req_i,
  input  port_idx_t            pointer_i,
  input  logic [NUM_PORTS-1:0] lockout_i,
  output logic                 valid_o,
  output port_idx_t            idx_o
);

  logic [NUM_PORTS-1:0] eligible;

  assign eligible = req_i & ~lockout_i;
  assign valid_o  = |eligible;

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
  // On contention the pointer (the port not served last) wins; otherwise
  // the single eligible port is taken.
  always_comb begin
    // NOTE: assign a default before any conditional so no latch is inferred.
    idx_o = pointer_i;
    if (!(&eligible)) begin
      idx_o = eligible[1];
    end
  end
`else
  // The pointer only matters for round-robin; keep it visibly consumed.
  logic unused_pointer;
  assign unused_pointer = pointer_i;

  // Fixed priority: port 0 wins whenever it is eligible.
  always_comb begin
    idx_o = 1'b1;
    if (eligible[0]) begin
      idx_o = 1'b0;
    end
  end
`endif

endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: two-port arbiter in front of an SDRAM controller.
// Port 0 is the CPU, port 1 is video/DMA. One access (burst) is granted at
// a time and runs IDLE -> GRANT -> XFER -> DRAIN -> DONE.
// Selection policy is set by SDRAM_ARB_ROUND_ROBIN_EN inside
// sdram_arb_select (fixed port-0 priority when undefined).
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 25,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_WIDTH  = 10
) (
  input  logic                  sdram_clock,
  input  logic                  reset,

  // Port 0 (CPU)
  input  logic [ADDR_WIDTH-1:0] p0_address,
  input  logic [NUM_WIDTH-1:0]  p0_access_num,
  input  logic [DATA_WIDTH-1:0] p0_data_in,
  input  logic                  p0_write_req,
  input  logic                  p0_read_req,
  output logic [DATA_WIDTH-1:0] p0_data_out,
  output logic                  p0_data_valid,
  output logic                  p0_write_strobe,
  output logic                  p0_done,
  output logic                  p0_busy,

  // Port 1 (video/DMA)
  input  logic [ADDR_WIDTH-1:0] p1_address,
  input  logic [NUM_WIDTH-1:0]  p1_access_num,
  input  logic [DATA_WIDTH-1:0] p1_data_in,
  input  logic                  p1_write_req,
  input  logic                  p1_read_req,
  output logic [DATA_WIDTH-1:0] p1_data_out,
  output logic                  p1_data_valid,
  output logic                  p1_write_strobe,
  output logic                  p1_done,
  output logic                  p1_busy,

  // SDRAM controller side
  output logic [ADDR_WIDTH-1:0] access_address,
  output logic [NUM_WIDTH-1:0]  access_num,
  output logic [DATA_WIDTH-1:0] access_data_in,
  input  logic [DATA_WIDTH-1:0] access_data_out,
  output logic                  write_request,
  output logic                  read_request,
  input  logic                  write_flag,
  input  logic                  read_flag,
  input  logic                  idle
);

  // Requester inputs gathered into port-indexed arrays.
  logic [ADDR_WIDTH-1:0] addr_a  [NUM_PORTS];
  logic [NUM_WIDTH-1:0]  num_a   [NUM_PORTS];
  logic [DATA_WIDTH-1:0] wdata_a [NUM_PORTS];
  logic [NUM_PORTS-1:0]  wr_req;
  logic [NUM_PORTS-1:0]  rd_req;

  assign addr_a[0]  = p0_address;
  assign addr_a[1]  = p1_address;
  assign num_a[0]   = p0_access_num;
  assign num_a[1]   = p1_access_num;
  assign wdata_a[0] = p0_data_in;
  assign wdata_a[1] = p1_data_in;
  assign wr_req     = {p1_write_req, p0_write_req};
  assign rd_req     = {p1_read_req, p0_read_req};

  // FSM state and registered control outputs.
  state_t               state_q;
  port_idx_t            grant_q;
  op_t                  op_q;
  logic                 write_request_q;
  logic                 read_request_q;
  logic [NUM_PORTS-1:0] busy_q;
  logic [NUM_PORTS-1:0] done_q;
  logic [NUM_PORTS-1:0] lockout_q;
  port_idx_t            ptr_q;

  // Read-data path.
  logic [DATA_WIDTH-1:0] rdata_q [NUM_PORTS];
  logic [DATA_WIDTH-1:0] rdata_d [NUM_PORTS];
  logic [NUM_PORTS-1:0]  rvalid_q;
  logic [NUM_PORTS-1:0]  rvalid_d;

  // Selection result for the IDLE state.
  logic      sel_valid;
  port_idx_t sel_idx;

  logic active;
  logic op_flag;

  // An access owns the controller from GRANT through DRAIN.
  assign active  = (state_q == GRANT) || (state_q == XFER) || (state_q == DRAIN);
  // The flag belonging to the latched operation ends the XFER phase.
  assign op_flag = (op_q == OP_WRITE) ? write_flag : read_flag;

  sdram_arb_select u_select (
    .req_i     (wr_req | rd_req),
    .pointer_i (ptr_q),
    .lockout_i (lockout_q),
    .valid_o   (sel_valid),
    .idx_o     (sel_idx)
  );

  // Arbiter FSM with registered request, busy and done outputs.
  always_ff @(posedge sdram_clock) begin
    if (reset) begin
      state_q         <= IDLE;
      grant_q         <= 1'b0;
      op_q            <= OP_READ;
      write_request_q <= 1'b0;
      read_request_q  <= 1'b0;
      busy_q          <= '0;
      done_q          <= '0;
      lockout_q       <= '0;
      ptr_q           <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      done_q    <= '0;
      lockout_q <= '0;
      case (state_q)
        IDLE: begin
          if (sel_valid) begin
            grant_q         <= sel_idx;
            // Write wins when a port raises both requests.
            op_q            <= wr_req[sel_idx] ? OP_WRITE : OP_READ;
            write_request_q <= wr_req[sel_idx];
            read_request_q  <= ~wr_req[sel_idx];
            busy_q          <= port_onehot(sel_idx);
            state_q         <= GRANT;
          end
        end
        GRANT: begin
          if (write_flag || read_flag) begin
            write_request_q <= 1'b0;
            read_request_q  <= 1'b0;
            state_q         <= XFER;
          end
        end
        XFER: begin
          if (!op_flag) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (idle) begin
            done_q  <= busy_q;
            state_q <= DONE;
          end
        end
        DONE: begin
          busy_q    <= '0;
          // The finished port sits out the next IDLE cycle.
          lockout_q <= busy_q;
          ptr_q     <= ~grant_q;
          state_q   <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Controller address/length/data follow the granted port while active.
  always_comb begin
    access_address = '0;
    access_num     = '0;
    access_data_in = '0;
    if (active) begin
      access_address = addr_a[grant_q];
      access_num     = num_a[grant_q];
      access_data_in = wdata_a[grant_q];
    end
  end

  // Capture each read word for the granted port; valid follows one cycle later.
  always_comb begin
    for (int n = 0; n < NUM_PORTS; n++) begin
      rdata_d[n]  = rdata_q[n];
      rvalid_d[n] = 1'b0;
      if (active && busy_q[n] && read_flag) begin
        rdata_d[n]  = access_data_out;
        rvalid_d[n] = 1'b1;
      end
    end
  end

  // Read-data registers; last word is held between strobes.
  always_ff @(posedge sdram_clock) begin
    if (reset) begin
      // NOTE: these data registers are reset only because the outputs must
      // read 0 after reset; plain storage arrays would be left unreset.
      for (int n = 0; n < NUM_PORTS; n++) begin
        rdata_q[n] <= '0;
      end
      rvalid_q <= '0;
    end else begin
      for (int n = 0; n < NUM_PORTS; n++) begin
        rdata_q[n] <= rdata_d[n];
      end
      rvalid_q <= rvalid_d;
    end
  end

  assign write_request   = write_request_q;
  assign read_request    = read_request_q;

  assign p0_data_out     = rdata_q[0];
  assign p0_data_valid   = rvalid_q[0];
  assign p0_write_strobe = busy_q[0] & write_flag;
  assign p0_done         = done_q[0];
  assign p0_busy         = busy_q[0];

  assign p1_data_out     = rdata_q[1];
  assign p1_data_valid   = rvalid_q[1];
  assign p1_write_strobe = busy_q[1] & write_flag;
  assign p1_done         = done_q[1];
  assign p1_busy         = busy_q[1];

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed bench for sdram_arbiter with a behavioural
// SDRAM controller model and a scoreboard monitor for grants, read words
// and completion pulses.
module tb_sdram_arbiter;

  localparam int AW = 25;
  localparam int DW = 16;
  localparam int NW = 10;

  localparam int EV_GRANT = 0;
  localparam int EV_XFER  = 1;
  localparam int EV_DONE  = 2;

  logic          sdram_clock;
  logic          reset;
  logic [AW-1:0] p0_address, p1_address;
  logic [NW-1:0] p0_access_num, p1_access_num;
  logic [DW-1:0] p0_data_in, p1_data_in;
  logic          p0_write_req, p0_read_req, p1_write_req, p1_read_req;
  logic [DW-1:0] p0_data_out, p1_data_out;
  logic          p0_data_valid, p0_write_strobe, p0_done, p0_busy;
  logic          p1_data_valid, p1_write_strobe, p1_done, p1_busy;
  logic [AW-1:0] access_address;
  logic [NW-1:0] access_num;
  logic [DW-1:0] access_data_in, access_data_out;
  logic          write_request, read_request;
  logic          write_flag, read_flag, idle;

  sdram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WIDTH(NW)) dut (
    .sdram_clock     (sdram_clock),
    .reset           (reset),
    .p0_address      (p0_address),
    .p0_access_num   (p0_access_num),
    .p0_data_in      (p0_data_in),
    .p0_write_req    (p0_write_req),
    .p0_read_req     (p0_read_req),
    .p0_data_out     (p0_data_out),
    .p0_data_valid   (p0_data_valid),
    .p0_write_strobe (p0_write_strobe),
    .p0_done         (p0_done),
    .p0_busy         (p0_busy),
    .p1_address      (p1_address),
    .p1_access_num   (p1_access_num),
    .p1_data_in      (p1_data_in),
    .p1_write_req    (p1_write_req),
    .p1_read_req     (p1_read_req),
    .p1_data_out     (p1_data_out),
    .p1_data_valid   (p1_data_valid),
    .p1_write_strobe (p1_write_strobe),
    .p1_done         (p1_done),
    .p1_busy         (p1_busy),
    .access_address  (access_address),
    .access_num      (access_num),
    .access_data_in  (access_data_in),
    .access_data_out (access_data_out),
    .write_request   (write_request),
    .read_request    (read_request),
    .write_flag      (write_flag),
    .read_flag       (read_flag),
    .idle            (idle)
  );

  initial begin
    sdram_clock = 1'b0;
    forever #5 sdram_clock = ~sdram_clock;
  end

  int cyc = 0;
  always @(posedge sdram_clock) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sdram_clock);
    #1;
  endtask

  // ---------------- scoreboard queues ----------------
  typedef struct {
    int port;
    bit wr;
  } grant_t;

  grant_t        exp_grant[$];
  int            exp_done[$];
  logic [DW-1:0] exp_rd0[$];
  logic [DW-1:0] exp_rd1[$];

  // ---------------- controller model ----------------
  typedef enum {M_IDLE, M_WAIT, M_BURST, M_TAIL} mstate_t;
  mstate_t       m_st;
  int            m_cnt, m_idx, m_len;
  bit            m_wr;
  logic [DW-1:0] rd_data [8];
  int            idle_rise_cyc = 0;

  initial begin
    m_st = M_IDLE;
    write_flag = 1'b0;
    read_flag = 1'b0;
    idle = 1'b1;
    access_data_out = '0;
    forever begin
      tick();
      if (reset) begin
        m_st = M_IDLE;
        write_flag = 1'b0;
        read_flag = 1'b0;
        idle = 1'b1;
      end else begin
        case (m_st)
          M_IDLE: if (write_request || read_request) begin
            m_wr  = write_request;
            m_len = int'(access_num);
            m_cnt = 2;
            idle  = 1'b0;
            m_st  = M_WAIT;
          end
          M_WAIT: if (m_cnt == 0) begin
            write_flag = m_wr;
            read_flag = !m_wr;
            access_data_out = rd_data[0];
            m_idx = 1;
            m_st = M_BURST;
          end else m_cnt--;
          M_BURST: if (m_idx >= m_len) begin
            write_flag = 1'b0;
            read_flag = 1'b0;
            m_cnt = 1;
            m_st = M_TAIL;
          end else begin
            access_data_out = rd_data[m_idx & 7];
            m_idx++;
          end
          M_TAIL: if (m_cnt == 0) begin
            idle = 1'b1;
            idle_rise_cyc = cyc;
            m_st = M_IDLE;
          end else m_cnt--;
          default: m_st = M_IDLE;
        endcase
      end
    end
  end

  // ---------------- monitor ----------------
  bit mon_en = 0;
  bit prev_busy = 0;
  int wstrobe_cnt0 = 0;
  int wreq_cnt = 0;
  int rdreq_cnt = 0;
  int last_done_cyc = 0;

  initial begin
    grant_t g;
    forever begin
      @(negedge sdram_clock);
      if (mon_en) begin
        check("one_busy", 64'(p0_busy & p1_busy), 64'd0);
        if (p0_busy || p1_busy) begin
          if (!prev_busy) begin
            if (exp_grant.size() == 0) check("unexpected_grant", 64'd1, 64'd0);
            else begin
              g = exp_grant.pop_front();
              check("grant_port", 64'(p1_busy), 64'(g.port));
              check("grant_wreq", 64'(write_request), 64'(g.wr));
              check("grant_rreq", 64'(read_request), 64'(!g.wr));
            end
          end
        end
        prev_busy = p0_busy | p1_busy;
        if (p0_data_valid) begin
          if (exp_rd0.size() == 0) check("unexpected_valid0", 64'd1, 64'd0);
          else check("rd0_data", 64'(p0_data_out), 64'(exp_rd0.pop_front()));
        end
        if (p1_data_valid) begin
          if (exp_rd1.size() == 0) check("unexpected_valid1", 64'd1, 64'd0);
          else check("rd1_data", 64'(p1_data_out), 64'(exp_rd1.pop_front()));
        end
        if (p0_done || p1_done) begin
          last_done_cyc = cyc;
          if (exp_done.size() == 0) check("unexpected_done", 64'd1, 64'd0);
          else check("done_port", 64'(p1_done), 64'(exp_done.pop_front()));
        end
        if (p0_write_strobe) wstrobe_cnt0++;
        if (write_request) wreq_cnt++;
        if (read_request) rdreq_cnt++;
      end
    end
  end

  // ---------------- helpers ----------------
  function automatic bit ev_true(input int kind, input int port);
    logic b, d;
    b = (port == 1) ? p1_busy : p0_busy;
    d = (port == 1) ? p1_done : p0_done;
    case (kind)
      EV_GRANT: return b;
      EV_XFER:  return b && !write_request && !read_request;
      default:  return d;
    endcase
  endfunction

  task automatic wait_event(input int kind, input int port, input string name);
    for (int i = 0; i < 300; i++) begin
      tick();
      if (ev_true(kind, port)) return;
    end
    check({"timeout_", name}, 64'd0, 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rdata"}, {p0_data_out, p1_data_out}, 64'd0);
    check({tag, "_access"}, 64'({access_address, access_num, access_data_in}), 64'd0);
    check({tag, "_ctl"}, 64'({p0_data_valid, p0_write_strobe, p0_done, p0_busy,
                              p1_data_valid, p1_write_strobe, p1_done, p1_busy,
                              write_request, read_request}), 64'd0);
  endtask

  task automatic set_rd(input logic [DW-1:0] base, input logic [DW-1:0] step);
    for (int i = 0; i < 8; i++) rd_data[i] = base + DW'(i) * step;
  endtask

  task automatic drop_all();
    p0_write_req = 0; p0_read_req = 0; p1_write_req = 0; p1_read_req = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int exp_w, winner;
    reset = 1'b1;
    p0_address = '0; p1_address = '0;
    p0_access_num = '0; p1_access_num = '0;
    p0_data_in = '0; p1_data_in = '0;
    drop_all();
    set_rd(16'h0000, 16'h0000);

    // Reset state
    tick(); tick();
    check_all_zero("reset");
    mon_en = 1;
    reset = 1'b0;
    tick();

    // p0 single-word write, request held into the post-DONE IDLE cycle
    p0_address = 25'h0001234; p0_access_num = 10'd1; p0_data_in = 16'h00A5;
    exp_grant.push_back('{port: 0, wr: 1'b1});
    exp_done.push_back(0);
    wstrobe_cnt0 = 0; wreq_cnt = 0;
    p0_write_req = 1;
    wait_event(EV_GRANT, 0, "t1_grant");
    check("t1_access_address", 64'(access_address), 64'h0001234);
    check("t1_access_num", 64'(access_num), 64'd1);
    check("t1_access_data_in", 64'(access_data_in), 64'h00A5);
    wait_event(EV_DONE, 0, "t1_done");
    tick();
    tick();
    p0_write_req = 0;
    tick(); tick();
    check("t1_lockout_no_regrant", 64'(p0_busy), 64'd0);
    check("t1_idle_access_zero", 64'(access_address), 64'd0);
    check("t1_write_strobes", 64'(wstrobe_cnt0), 64'd1);
    check("t1_write_req_cycles", 64'(wreq_cnt), 64'd4);
    check("t1_done_after_idle", 64'(last_done_cyc - idle_rise_cyc), 64'd1);

    // p1 four-word read
    set_rd(16'h1111, 16'h1111);
    p1_address = 25'h0100000; p1_access_num = 10'd4;
    exp_grant.push_back('{port: 1, wr: 1'b0});
    for (int i = 0; i < 4; i++) exp_rd1.push_back(16'h1111 * DW'(i + 1));
    exp_done.push_back(1);
    p1_read_req = 1;
    wait_event(EV_DONE, 1, "t2_done");
    p1_read_req = 0;
    check("t2_data_at_done", 64'(p1_data_out), 64'h4444);
    tick(); tick(); tick();
    check("t2_data_hold", 64'(p1_data_out), 64'h4444);
    check("t2_valid_low", 64'(p1_data_valid), 64'd0);
    check("t2_reads_consumed", 64'(exp_rd1.size()), 64'd0);

    // p0 drops its read request during XFER
    set_rd(16'hA001, 16'h0001);
    p0_address = 25'h0000200; p0_access_num = 10'd4;
    exp_grant.push_back('{port: 0, wr: 1'b0});
    for (int i = 0; i < 4; i++) exp_rd0.push_back(16'hA001 + DW'(i));
    exp_done.push_back(0);
    p0_read_req = 1;
    wait_event(EV_XFER, 0, "t3_xfer");
    p0_read_req = 0;
    wait_event(EV_DONE, 0, "t3_done");
    tick(); tick(); tick();
    check("t3_no_regrant", 64'(p0_busy), 64'd0);
    check("t3_reads_consumed", 64'(exp_rd0.size()), 64'd0);

    // p0 with both write and read high is served as a write
    p0_address = 25'h0000300; p0_access_num = 10'd2;
    exp_grant.push_back('{port: 0, wr: 1'b1});
    exp_done.push_back(0);
    wstrobe_cnt0 = 0; wreq_cnt = 0; rdreq_cnt = 0;
    p0_write_req = 1; p0_read_req = 1;
    wait_event(EV_DONE, 0, "t5_done");
    drop_all();
    tick(); tick();
    check("t5_read_req_never", 64'(rdreq_cnt), 64'd0);
    check("t5_write_req_cycles", 64'(wreq_cnt), 64'd4);
    check("t5_write_strobes", 64'(wstrobe_cnt0), 64'd2);

    // Simultaneous requests, three rounds, pointer starting at port 0
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    p0_access_num = 10'd1; p1_access_num = 10'd1;
    for (int r = 0; r < 3; r++) begin
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
      exp_w = r % 2;
`else
      exp_w = 0;
`endif
      exp_grant.push_back('{port: exp_w, wr: 1'b1});
      exp_done.push_back(exp_w);
      p0_write_req = 1; p1_write_req = 1;
      for (int i = 0; i < 300; i++) begin
        tick();
        if (p0_done || p1_done) break;
        if (i == 299) check("timeout_arb_done", 64'd0, 64'd1);
      end
      winner = p1_done ? 1 : 0;
      check("arb_round_winner", 64'(winner), 64'(exp_w));
      drop_all();
      tick(); tick(); tick();
    end

    // Reset during XFER of a four-word read: no completion pulse
    set_rd(16'hB001, 16'h0001);
    p1_address = 25'h0000400; p1_access_num = 10'd4;
    exp_grant.push_back('{port: 1, wr: 1'b0});
    exp_rd1.push_back(16'hB001);
    p1_read_req = 1;
    wait_event(EV_XFER, 1, "t4_xfer");
    reset = 1'b1;
    tick();
    check_all_zero("midrst");
    p1_read_req = 0;
    tick();
    reset = 1'b0;
    repeat (10) tick();
    check("midrst_still_idle", 64'({p0_busy, p1_busy}), 64'd0);

    check("end_grant_queue", 64'(exp_grant.size()), 64'd0);
    check("end_done_queue", 64'(exp_done.size()), 64'd0);
    check("end_rd0_queue", 64'(exp_rd0.size()), 64'd0);
    check("end_rd1_queue", 64'(exp_rd1.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
